// File: rtl/rom_dl_router_pkg.sv
// Shared types for the ROM download router.
// FSM state encoding and region-select field width.
package rom_dl_router_pkg;

    typedef enum logic [1:0] {
        RELEASE,
        IDLE,
        LOAD,
        DRAIN
    } dl_state_e;

    localparam int REGION_W = 3;

endpackage

// File: rtl/dl_throttle.sv
// Issue register with ioctl_wait stall counter and a one-entry
// pending buffer for a byte that arrives while stalled.
module dl_throttle #(
    parameter int DW          = 25,
    parameter int WAIT_CYCLES = 0
) (
    input  logic          clk_sys,
    input  logic          RESET_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          issue,
    output logic [DW-1:0] issue_data,
    output logic          stall,
    output logic          busy,
    output logic          drop
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    logic [3:0]    wait_cnt;
    logic          pend_valid;
    logic [DW-1:0] pend_data;

    assign stall = wait_cnt != 4'd0;
    assign busy  = stall | pend_valid;
    assign drop  = in_valid & stall & pend_valid;

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            wait_cnt   <= 4'd0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
            issue      <= 1'b0;
            issue_data <= '0;
        end else begin
            issue <= 1'b0;
            if (stall) begin
                wait_cnt <= wait_cnt - 4'd1;
                if (in_valid && !pend_valid) begin
                    pend_valid <= 1'b1;
                    pend_data  <= in_data;
                end
            end else if (pend_valid) begin
                // stall just ended: drain the buffer, refill it if a byte is arriving now
                issue      <= 1'b1;
                issue_data <= pend_data;
                wait_cnt   <= WAIT_LOAD;
                pend_valid <= in_valid;
                if (in_valid) begin
                    pend_data <= in_data;
                end
            end else if (in_valid) begin
                issue      <= 1'b1;
                issue_data <= in_data;
                wait_cnt   <= WAIT_LOAD;
            end
        end
    end

endmodule

// File: rtl/rom_dl_router.sv
// Routes HPS ioctl ROM download bytes to one-hot region sinks and
// holds the game core in reset while a load is in flight.
module rom_dl_router
    import rom_dl_router_pkg::*;
#(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 14,
    parameter int INDEX       = 0,
    parameter int WAIT_CYCLES = 0,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                   clk_sys,
    input  logic                   RESET_n,
    input  logic                   ioctl_download,
    input  logic [7:0]             ioctl_index,
    input  logic                   ioctl_wr,
    input  logic [24:0]            ioctl_addr,
    input  logic [7:0]             ioctl_dout,
    output logic                   ioctl_wait,
    output logic [ADDR_W-1:0]      dn_addr,
    output logic [7:0]             dn_data,
    output logic [NUM_REGIONS-1:0] dn_wr,
    output logic [NUM_REGIONS-1:0] region_loaded,
    output logic                   overflow,
    output logic                   core_reset,
    output logic [24:0]            byte_count
);

    localparam int         DW        = REGION_W + ADDR_W + 8;
    localparam logic [3:0] NUM_R     = 4'(NUM_REGIONS);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    dl_state_e state, next_state;

    logic [7:0]            hold_cnt;
    logic [NUM_REGIONS-1:0] hit_mask;
    logic                  idx_match, active, accept;
    logic                  out_of_range, fwd, bad;
    logic [REGION_W-1:0]   sel, iss_sel;
    logic [24:0]           high_bits;
    logic                  issue, thr_stall, thr_busy, thr_drop;
    logic [DW-1:0]         issue_data;
    logic                  start, finish, wrap, ovf_set;

    assign idx_match = ioctl_index == 8'(INDEX);
    assign active    = ioctl_download & idx_match;
    assign sel       = ioctl_addr[ADDR_W +: REGION_W];
    assign high_bits = ioctl_addr >> (ADDR_W + REGION_W);

    assign out_of_range = ({1'b0, sel} >= NUM_R) || (high_bits != '0);

    // LOAD keeps accepting for the cycle in which ioctl_download falls
    assign accept = ioctl_wr & idx_match &
                    ((state == LOAD) ||
                     (ioctl_download && (state == IDLE || state == RELEASE)));

    assign fwd = accept & ~out_of_range;
    assign bad = accept & out_of_range;

    dl_throttle #(
        .DW          (DW),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_throttle (
        .clk_sys    (clk_sys),
        .RESET_n    (RESET_n),
        .in_valid   (fwd),
        .in_data    ({sel, ioctl_addr[ADDR_W-1:0], ioctl_dout}),
        .issue      (issue),
        .issue_data (issue_data),
        .stall      (thr_stall),
        .busy       (thr_busy),
        .drop       (thr_drop)
    );

    assign ioctl_wait = thr_stall;
    assign iss_sel    = issue_data[DW-1 -: REGION_W];
    assign dn_addr    = issue_data[8 +: ADDR_W];
    assign dn_data    = issue_data[7:0];

    always_comb begin
        dn_wr = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (issue && iss_sel == REGION_W'(i)) begin
                dn_wr[i] = 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            RELEASE: begin
                if (active) begin
                    next_state = LOAD;
                end else if (hold_cnt == HOLD_LAST) begin
                    next_state = IDLE;
                end
            end
            IDLE: begin
                if (active) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (!active) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (!thr_busy) begin
                    next_state = RELEASE;
                end
            end
        endcase
    end

    assign start   = (next_state == LOAD) && (state != LOAD);
    assign finish  = (state == DRAIN) && (next_state == RELEASE);
    assign wrap    = issue && (byte_count == '1);
    assign ovf_set = bad | thr_drop | wrap;

    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            state         <= RELEASE;
            core_reset    <= 1'b1;
            hold_cnt      <= 8'd0;
            hit_mask      <= '0;
            region_loaded <= '0;
            overflow      <= 1'b0;
            byte_count    <= '0;
        end else begin
            state      <= next_state;
            core_reset <= next_state != IDLE;
            if (state == RELEASE && next_state == RELEASE) begin
                hold_cnt <= hold_cnt + 8'd1;
            end else begin
                hold_cnt <= 8'd0;
            end
            if (start) begin
                byte_count    <= '0;
                hit_mask      <= '0;
                region_loaded <= '0;
                overflow      <= ovf_set;
            end else begin
                if (issue) begin
                    byte_count <= byte_count + 25'd1;
                end
                hit_mask <= hit_mask | dn_wr;
                overflow <= overflow | ovf_set;
                if (finish) begin
                    region_loaded <= hit_mask | dn_wr;
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_dl_router.sv
// Randomized scoreboard bench for rom_dl_router, run side by side
// with WAIT_CYCLES=0 and WAIT_CYCLES=2 instances.
module tb_rom_dl_router;

    localparam int NR = 4;
    localparam int AW = 14;

    typedef struct {
        int         t;
        logic [3:0] wr;
        logic [13:0] a;
        logic [7:0] d;
    } exp_t;

    logic        clk_sys = 1'b0;
    logic        RESET_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = 8'd0;

    logic        w0, w2, ov0, ov2, cr0, cr2;
    logic [13:0] da0, da2;
    logic [7:0]  dd0, dd2;
    logic [3:0]  dw0, dw2, rl0, rl2;
    logic [24:0] bc0, bc2;

    rom_dl_router #(.NUM_REGIONS(NR), .ADDR_W(AW), .INDEX(0),
                    .WAIT_CYCLES(0), .HOLD_CYCLES(16)) u0 (
        .clk_sys(clk_sys), .RESET_n(RESET_n),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(w0),
        .dn_addr(da0), .dn_data(dd0), .dn_wr(dw0),
        .region_loaded(rl0), .overflow(ov0),
        .core_reset(cr0), .byte_count(bc0)
    );

    rom_dl_router #(.NUM_REGIONS(NR), .ADDR_W(AW), .INDEX(0),
                    .WAIT_CYCLES(2), .HOLD_CYCLES(16)) u2 (
        .clk_sys(clk_sys), .RESET_n(RESET_n),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(w2),
        .dn_addr(da2), .dn_data(dd2), .dn_wr(dw2),
        .region_loaded(rl2), .overflow(ov2),
        .core_reset(cr2), .byte_count(bc2)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   last_iss[2];
    int   lsched[2];
    int   ebc[2];
    logic [3:0] erl[2];
    bit   eov[2];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // byte written in cycle c: issues next cycle unless a stall window
    // (W cycles after each issue) or a queued byte is in the way
    task automatic model_write(int k, int c, logic [24:0] a, logic [7:0] d);
        int   w = (k == 0) ? 0 : 2;
        int   t;
        int   r;
        exp_t e;
        if (a >= 25'(NR << AW)) begin
            eov[k] = 1;
            return;
        end
        if (lsched[k] > c + 1) begin
            eov[k] = 1;
            return;
        end
        t = (lsched[k] + w <= c) ? c + 1 : lsched[k] + w + 1;
        lsched[k] = t;
        r = int'(a) / (1 << AW);
        e.t = t;
        e.wr = 4'(1 << r);
        e.a = 14'(int'(a) % (1 << AW));
        e.d = d;
        ebc[k]++;
        erl[k] |= e.wr;
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic mon_one(int k, logic [3:0] dw, logic [13:0] da,
                           logic [7:0] dd, logic wt);
        int   w = (k == 0) ? 0 : 2;
        bit   due = 0;
        exp_t e;
        if (k == 0 && q0.size() > 0 && q0[0].t == cyc) begin
            e = q0.pop_front();
            due = 1;
        end
        if (k == 1 && q1.size() > 0 && q1[0].t == cyc) begin
            e = q1.pop_front();
            due = 1;
        end
        if (due) begin
            last_iss[k] = e.t;
            chk($sformatf("dn_wr[%0d]", k), 32'(dw), 32'(e.wr));
            chk($sformatf("dn_addr[%0d]", k), 32'(da), 32'(e.a));
            chk($sformatf("dn_data[%0d]", k), 32'(dd), 32'(e.d));
        end else if (dw != 4'd0) begin
            chk($sformatf("spurious dn_wr[%0d]", k), 32'(dw), 32'd0);
        end
        chk($sformatf("ioctl_wait[%0d]", k), 32'(wt),
            32'((cyc >= last_iss[k]) && (cyc < last_iss[k] + w)));
    endtask

    always @(negedge clk_sys) begin
        if (mon_en) begin
            mon_one(0, dw0, da0, dd0, w0);
            mon_one(1, dw2, da2, dd2, w2);
        end
    end

    task automatic drive(bit dl, bit w, logic [24:0] a = '0, logic [7:0] d = 8'd0);
        @(negedge clk_sys);
        ioctl_download = dl;
        ioctl_wr = w;
        ioctl_addr = a;
        ioctl_dout = d;
        if (w && ioctl_index == 8'd0) begin
            model_write(0, cyc, a, d);
            model_write(1, cyc, a, d);
        end
    endtask

    task automatic idle(int n);
        repeat (n) drive(ioctl_download, 1'b0);
    endtask

    task automatic start_session();
        for (int k = 0; k < 2; k++) begin
            ebc[k] = 0;
            erl[k] = 4'd0;
            eov[k] = 0;
        end
    endtask

    task automatic check_session(string tag);
        chk({tag, " byte_count[0]"}, 32'(bc0), 32'(ebc[0]));
        chk({tag, " byte_count[1]"}, 32'(bc2), 32'(ebc[1]));
        chk({tag, " region_loaded[0]"}, 32'(rl0), 32'(erl[0]));
        chk({tag, " region_loaded[1]"}, 32'(rl2), 32'(erl[1]));
        chk({tag, " overflow[0]"}, 32'(ov0), 32'(eov[0]));
        chk({tag, " overflow[1]"}, 32'(ov2), 32'(eov[1]));
    endtask

    task automatic chk_reset(string tag);
        chk({tag, " core_reset[0]"}, 32'(cr0), 32'd1);
        chk({tag, " core_reset[1]"}, 32'(cr2), 32'd1);
        chk({tag, " wait[0]"}, 32'(w0), 32'd0);
        chk({tag, " wait[1]"}, 32'(w2), 32'd0);
        chk({tag, " dn_wr[0]"}, 32'(dw0), 32'd0);
        chk({tag, " dn_wr[1]"}, 32'(dw2), 32'd0);
        chk({tag, " dn_addr[0]"}, 32'(da0), 32'd0);
        chk({tag, " dn_addr[1]"}, 32'(da2), 32'd0);
        chk({tag, " dn_data[0]"}, 32'(dd0), 32'd0);
        chk({tag, " dn_data[1]"}, 32'(dd2), 32'd0);
        chk({tag, " region_loaded[0]"}, 32'(rl0), 32'd0);
        chk({tag, " region_loaded[1]"}, 32'(rl2), 32'd0);
        chk({tag, " overflow[0]"}, 32'(ov0), 32'd0);
        chk({tag, " overflow[1]"}, 32'(ov2), 32'd0);
        chk({tag, " byte_count[0]"}, 32'(bc0), 32'd0);
        chk({tag, " byte_count[1]"}, 32'(bc2), 32'd0);
    endtask

    // cycles from reset release until core_reset is first seen low
    task automatic hold_test(string tag);
        int h0 = 0;
        int h2 = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk_sys);
            if (h0 == 0 && !cr0) h0 = i;
            if (h2 == 0 && !cr2) h2 = i;
        end
        chk({tag, " hold cycles[0]"}, 32'(h0), 32'd16);
        chk({tag, " hold cycles[1]"}, 32'(h2), 32'd16);
    endtask

    task automatic clear_model();
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            last_iss[k] = -1000;
            lsched[k] = -1000;
        end
        start_session();
    endtask

    initial begin
        logic [24:0] a;
        clear_model();
        repeat (3) @(negedge clk_sys);
        chk_reset("por");
        RESET_n = 1'b1;
        mon_en = 1;
        hold_test("por");

        ioctl_index = 8'd1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'(i % 2), 25'(i * 25'h4001), 8'(i + 1));
            chk("foreign index core_reset[0]", 32'(cr0), 32'd0);
            chk("foreign index core_reset[1]", 32'(cr2), 32'd0);
        end
        drive(1'b0, 1'b0);
        ioctl_index = 8'd0;
        idle(3);
        check_session("idx");

        start_session();
        drive(1'b1, 1'b1, 25'h0000, 8'hA5);
        idle(4);
        drive(1'b1, 1'b1, 25'h4001, 8'h3C);
        idle(4);
        drive(1'b0, 1'b0);
        idle(20);
        check_session("two byte");
        idle(10);

        start_session();
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1, 25'h0100, 8'h11);
        drive(1'b1, 1'b1, 25'h0101, 8'h22);
        drive(1'b1, 1'b1, 25'h0102, 8'h33);
        idle(6);
        drive(1'b0, 1'b0);
        idle(20);
        check_session("burst");
        idle(10);

        start_session();
        drive(1'b1, 1'b1, 25'h10000, 8'h44);
        idle(3);
        drive(1'b1, 1'b1, 25'h03FFF, 8'h5A);
        idle(4);
        drive(1'b0, 1'b0);
        idle(20);
        check_session("out of range");
        idle(10);

        start_session();
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = (25'($urandom_range(0, 3)) << AW) | 25'($urandom_range(0, 16383));
                if ($urandom_range(0, 7) == 0) begin
                    if ($urandom_range(0, 1) == 1)
                        a = (25'($urandom_range(4, 7)) << AW) | 25'($urandom_range(0, 16383));
                    else
                        a = a | (25'd1 << $urandom_range(17, 24));
                end
                drive(1'b1, 1'b1, a, 8'($urandom));
            end else begin
                drive(1'b1, 1'b0);
            end
        end
        drive(1'b0, 1'b1, 25'h0C123, 8'hE7);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0);
            chk("drain core_reset[0]", 32'(cr0), 32'd1);
            chk("drain core_reset[1]", 32'(cr2), 32'd1);
        end
        check_session("random");

        start_session();
        drive(1'b1, 1'b1, 25'h08005, 8'h99);
        chk("restart core_reset[0]", 32'(cr0), 32'd1);
        chk("restart core_reset[1]", 32'(cr2), 32'd1);
        drive(1'b1, 1'b0);
        chk("restart core_reset[0]", 32'(cr0), 32'd1);
        chk("restart core_reset[1]", 32'(cr2), 32'd1);
        idle(3);
        drive(1'b1, 1'b1, 25'h0C00F, 8'h66);
        idle(4);
        drive(1'b0, 1'b0);
        idle(20);
        check_session("restart");
        idle(10);

        start_session();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 25'(i) * 25'h4003, 8'(8'h50 + i));
            idle(2);
        end
        idle(3);
        chk("queue[0] drained", 32'(q0.size()), 32'd0);
        chk("queue[1] drained", 32'(q1.size()), 32'd0);
        @(negedge clk_sys);
        RESET_n = 1'b0;
        mon_en = 0;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        #1;
        chk_reset("mid load");
        clear_model();
        repeat (2) @(negedge clk_sys);
        RESET_n = 1'b1;
        mon_en = 1;
        hold_test("mid load");
        idle(3);
        chk("final queue[0]", 32'(q0.size()), 32'd0);
        chk("final queue[1]", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rom_dl_router.md
ROM_DL_ROUTER -- requirements
Module: rom_dl_router

Interface
REQ-001 The block SHALL have the parameter NUM_REGIONS, default 4: number of ROM sink regions, 1..8.
REQ-002 The block SHALL have the parameter ADDR_W, default 14: region-local address width; each region spans 2^ADDR_W bytes.
REQ-003 The block SHALL have the parameter INDEX, default 0: ioctl_index value that selects ROM download.
REQ-004 The block SHALL have the parameter WAIT_CYCLES, default 0: ioctl_wait stall cycles per issued byte, 0..15.
REQ-005 The block SHALL have the parameter HOLD_CYCLES, default 16: core_reset hold after load completes, 1..255.
REQ-006 The block SHALL have these ports:
- clk_sys  in  1  system clock, all logic on rising edge.
- RESET_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  download target index.
- ioctl_wr  in  1  byte strobe, one cycle.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  back-pressure to HPS.
- dn_addr  out  ADDR_W  region-local address.
- dn_data  out  8  byte to sink.
- dn_wr  out  NUM_REGIONS  one-hot write strobe.
- region_loaded  out  NUM_REGIONS  region received at least one byte in the last completed download.
- overflow  out  1  sticky: byte outside all regions or dropped.
- core_reset  out  1  active-high hold for the game core.
- byte_count  out  25  bytes accepted in the current or last download.

Function
REQ-007 The block SHALL define active as ioctl_download=1 and ioctl_index==INDEX; writes SHALL be ignored at all other times.
REQ-008 The block SHALL select the region as ioctl_addr[ADDR_W +: 3]; region >= NUM_REGIONS, or any address bit above ADDR_W+2 set, SHALL drop the byte and set overflow.
REQ-009 The block SHALL issue an ioctl_wr accepted in cycle N in cycle N+1, driving dn_wr[region]=1 for exactly one cycle.
REQ-010 In that cycle dn_addr SHALL equal ioctl_addr[ADDR_W-1:0] and dn_data SHALL equal ioctl_dout, and both SHALL hold until the next issue.
REQ-011 The block SHALL assert ioctl_wait for cycles N+1..N+WAIT_CYCLES; with WAIT_CYCLES=0 it SHALL never assert it.
REQ-012 A write arriving while waiting SHALL be captured in a one-entry pending buffer and issued the cycle after the wait ends.
REQ-013 A further write arriving while the pending buffer is full SHALL be dropped and SHALL set overflow.
REQ-014 The block SHALL increment byte_count once per issued byte; a byte_count increment at 2^25-1 SHALL wrap to 0 and SHALL set overflow.
REQ-015 The FSM SHALL implement these states:
- RELEASE: core_reset=1, counting HOLD_CYCLES, then IDLE.
- IDLE: core_reset=0; on active -> LOAD, clearing byte_count, overflow and the region-hit mask.
- LOAD: core_reset=1, issuing writes; on active falling -> DRAIN.
- DRAIN: waits until the wait counter and the pending buffer are empty, then copies the hit mask to region_loaded and goes to RELEASE.
REQ-016 If active and ioctl_wr coincide with the IDLE->LOAD transition, the byte SHALL be accepted.
REQ-017 ioctl_download falling simultaneously with ioctl_wr SHALL accept that byte before DRAIN completes.
REQ-018 A new download starting during RELEASE SHALL go directly to LOAD, keeping core_reset=1 without glitch.
REQ-019 region_loaded SHALL be cleared on entry to LOAD.

Reset
REQ-020 Asserting RESET_n=0 at any time, including mid-download, SHALL abort immediately.
REQ-021 Reset values SHALL be: state RELEASE; core_reset=1; ioctl_wait=0; dn_wr=0; dn_addr=0; dn_data=0; region_loaded=0; overflow=0; byte_count=0; pending buffer empty.

Structure
REQ-022 A shared package SHALL hold the FSM state enum (RELEASE, IDLE, LOAD, DRAIN) and the region-select width constant (3).
REQ-023 The wait counter plus pending buffer SHALL be one sub-module, dl_throttle.

Verification
REQ-024 Reset release with no download SHALL give core_reset=1 for exactly 16 cycles, then 0.
REQ-025 With WAIT_CYCLES=0, writes 0x0000=0xA5 and 0x4001=0x3C SHALL produce dn_wr=0001 with addr 0x0000, then dn_wr=0010 with addr 0x0001, each 1 cycle after the strobe; after end, region_loaded=0011 and byte_count=2.
REQ-026 With WAIT_CYCLES=2, strobes on consecutive cycles SHALL give ioctl_wait=1 for 2 cycles, the 2nd byte issued on the 3rd cycle after the 1st issue, and the 3rd byte dropped with overflow=1.
REQ-027 Address 0x10000 with NUM_REGIONS=4 SHALL give no dn_wr, overflow=1 and byte_count unchanged.
REQ-028 RESET_n pulsed low mid-LOAD after 5 bytes SHALL clear all outputs to reset values, and core_reset SHALL stay 1 through RELEASE.
REQ-029 ioctl_index=1 with strobes SHALL give no dn_wr, core_reset=0 and no state change.
